// File: rtl/pika_pkg.sv
// Shared PikaRISC decode definitions: immediate format encoding, default widths
// and a small width helper.
package pika_pkg;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 18;
    localparam int MD_W   = 22;
    localparam int UP_W   = 14;
    localparam int TAG_W  = 5;

    typedef enum logic [1:0] {
        FMT_SEXT_IMM = 2'b00,
        FMT_SEXT_MD  = 2'b01,
        FMT_ZEXT_IMM = 2'b10,
        FMT_UPPER    = 2'b11
    } fmt_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: maps a raw LSB-aligned field and a format
// select onto a DATA_W-bit operand.
module imm_extend_core
    import pika_pkg::*;
#(
    parameter int DATA_W = pika_pkg::DATA_W,
    parameter int IMM_W  = pika_pkg::IMM_W,
    parameter int MD_W   = pika_pkg::MD_W,
    parameter int UP_W   = pika_pkg::UP_W,
    parameter int IN_W   = max3(IMM_W, MD_W, UP_W)
) (
    input  logic [IN_W-1:0]   field,
    input  fmt_e              fmt,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] up_val;

    // Upper immediate lands in the top UP_W bits; the bit-wise build also
    // covers UP_W == DATA_W without a zero-width replication.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_up
        if (gi >= DATA_W - UP_W) begin : g_hi
            assign up_val[gi] = field[gi-(DATA_W-UP_W)];
        end else begin : g_lo
            assign up_val[gi] = 1'b0;
        end
    end

    always_comb begin
        data = '0;
        unique case (fmt)
            FMT_SEXT_IMM: data = {{(DATA_W-IMM_W){field[IMM_W-1]}}, field[IMM_W-1:0]};
            FMT_SEXT_MD:  data = {{(DATA_W-MD_W){field[MD_W-1]}}, field[MD_W-1:0]};
            FMT_ZEXT_IMM: data = {{(DATA_W-IMM_W){1'b0}}, field[IMM_W-1:0]};
            FMT_UPPER:    data = up_val;
            default:      data = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered valid/ready immediate extension stage with tag sideband.
// Define IMMEXT_SKID_EN for a registered in_ready backed by a one-entry skid.
module imm_extend_pipe
    import pika_pkg::*;
#(
    parameter int DATA_W = pika_pkg::DATA_W,
    parameter int IMM_W  = pika_pkg::IMM_W,
    parameter int MD_W   = pika_pkg::MD_W,
    parameter int UP_W   = pika_pkg::UP_W,
    parameter int TAG_W  = pika_pkg::TAG_W,
    localparam int IN_W  = max3(IMM_W, MD_W, UP_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_field,
    input  logic [1:0]        in_fmt,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_neg
);

    logic [DATA_W-1:0] ext_data;
    logic              in_xfer;
    logic              out_xfer;

    logic              out_valid_reg, out_valid_next;
    logic [DATA_W-1:0] out_data_reg,  out_data_next;
    logic [TAG_W-1:0]  out_tag_reg,   out_tag_next;

    // Extension happens before any storage, so held entries are final operands.
    imm_extend_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .MD_W   (MD_W),
        .UP_W   (UP_W),
        .IN_W   (IN_W)
    ) u_core (
        .field (in_field),
        .fmt   (fmt_e'(in_fmt)),
        .data  (ext_data)
    );

    assign out_xfer = out_valid_reg & out_ready;

`ifdef IMMEXT_SKID_EN
    logic              skid_valid_reg, skid_valid_next;
    logic [DATA_W-1:0] skid_data_reg,  skid_data_next;
    logic [TAG_W-1:0]  skid_tag_reg,   skid_tag_next;
    logic              in_ready_reg;

    assign in_ready = in_ready_reg;
    assign in_xfer  = in_valid & in_ready_reg;

    // in_ready_reg tracks "skid empty", so it only drops once the skid has taken
    // an entry; a full skid blocks new input, keeping the drain path simple.
    always_comb begin
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_tag_next    = out_tag_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_tag_next   = skid_tag_reg;
        if (out_xfer) begin
            if (skid_valid_reg) begin
                out_data_next   = skid_data_reg;
                out_tag_next    = skid_tag_reg;
                skid_valid_next = 1'b0;
            end else if (in_xfer) begin
                out_data_next = ext_data;
                out_tag_next  = in_tag;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (!out_valid_reg) begin
            if (in_xfer) begin
                out_valid_next = 1'b1;
                out_data_next  = ext_data;
                out_tag_next   = in_tag;
            end
        end else if (in_xfer) begin
            skid_valid_next = 1'b1;
            skid_data_next  = ext_data;
            skid_tag_next   = in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_tag_reg   <= '0;
            in_ready_reg   <= 1'b1;
        end else begin
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_tag_reg   <= skid_tag_next;
            in_ready_reg   <= !skid_valid_next;
        end
    end
`else
    assign in_ready = !out_valid_reg | out_ready;
    assign in_xfer  = in_valid & in_ready;

    always_comb begin
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_tag_next   = out_tag_reg;
        if (in_xfer) begin
            out_valid_next = 1'b1;
            out_data_next  = ext_data;
            out_tag_next   = in_tag;
        end else if (out_xfer) begin
            out_valid_next = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_tag_reg   <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_tag_reg   <= out_tag_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_tag   = out_tag_reg;
    assign out_neg   = out_data_reg[DATA_W-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed format vectors, stall/order sequence,
// random valid/ready traffic against a queue scoreboard, and reset mid-stall.
module tb_imm_extend_pipe;

    localparam int DATA_W = 32;
    localparam int IMM_W  = 18;
    localparam int MD_W   = 22;
    localparam int UP_W   = 14;
    localparam int TAG_W  = 5;
    localparam int IN_W   = 22;
`ifdef IMMEXT_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IN_W-1:0]   in_field = '0;
    logic [1:0]        in_fmt = 2'b00;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_neg;

    imm_extend_pipe #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .MD_W   (MD_W),
        .UP_W   (UP_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_field  (in_field),
        .in_fmt    (in_fmt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_neg   (out_neg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    entry_t           sb[$];
    logic [TAG_W-1:0] outq[$];
    logic             hold_chk = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [TAG_W-1:0]  prev_tag;
    logic             accepted = 1'b0;
    int               nout = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference extension from the format rules using plain integer arithmetic.
    function automatic logic [DATA_W-1:0] ref_ext(input logic [IN_W-1:0] f, input logic [1:0] fmt);
        longint v;
        longint fv;
        fv = longint'(f);
        case (fmt)
            2'b00: begin
                v = fv % (longint'(1) << IMM_W);
                if (v >= (longint'(1) << (IMM_W - 1))) v = v - (longint'(1) << IMM_W);
            end
            2'b01: begin
                v = fv % (longint'(1) << MD_W);
                if (v >= (longint'(1) << (MD_W - 1))) v = v - (longint'(1) << MD_W);
            end
            2'b10: v = fv % (longint'(1) << IMM_W);
            default: v = (fv % (longint'(1) << UP_W)) * (longint'(1) << (DATA_W - UP_W));
        endcase
        return v[DATA_W-1:0];
    endfunction

    // One clock with inputs already driven: check against the occupancy model,
    // score any transfers, then advance to just after the next rising edge.
    task automatic step();
        logic exp_ready;
        logic in_x;
        logic out_x;
        entry_t e;
        @(negedge clk);
        if (CAP == 2) exp_ready = (sb.size() < 2);
        else          exp_ready = (sb.size() == 0) || out_ready;
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, sb.size() > 0);
        if (hold_chk) begin
            chk("stall_data", out_data, prev_data);
            chk("stall_tag", out_tag, prev_tag);
        end
        in_x  = in_valid & in_ready;
        out_x = out_valid & out_ready;
        if (out_x) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_tag", out_tag, e.tag);
                chk("out_neg", out_neg, e.data[DATA_W-1]);
            end
            outq.push_back(out_tag);
            nout++;
        end
        if (in_x) begin
            e.data = ref_ext(in_field, in_fmt);
            e.tag  = in_tag;
            sb.push_back(e);
        end
        hold_chk  = out_valid && !out_ready;
        prev_data = out_data;
        prev_tag  = out_tag;
        accepted  = in_x;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [IN_W-1:0]   field;
        logic [1:0]        fmt;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] exp_data;
        logic              exp_neg;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        int stall_acc;
        int guard;

        vecs[0] = '{22'h020000, 2'b00, 5'd1, 32'hFFFE0000, 1'b1};
        vecs[1] = '{22'h01FFFF, 2'b00, 5'd2, 32'h0001FFFF, 1'b0};
        vecs[2] = '{22'h200001, 2'b01, 5'd3, 32'hFFE00001, 1'b1};
        vecs[3] = '{22'h3FFFFF, 2'b10, 5'd4, 32'h0003FFFF, 1'b0};
        vecs[4] = '{22'h002ABC, 2'b11, 5'd5, 32'hAAF00000, 1'b1};
        vecs[5] = '{22'h3EAABC, 2'b11, 5'd6, 32'hAAF00000, 1'b1};
        vecs[6] = '{22'h3DFFFF, 2'b00, 5'd7, 32'h0001FFFF, 1'b0};

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_neg", out_neg, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Directed formats: one-cycle latency with out_ready high
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_field = vecs[i].field;
            in_fmt   = vecs[i].fmt;
            in_tag   = vecs[i].tag;
            @(negedge clk);
            chk("vec_in_ready", in_ready, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            $display("vec %0d field=%0h fmt=%0d -> data=%0h neg=%0b tag=%0d", i, vecs[i].field,
                     vecs[i].fmt, out_data, out_neg, out_tag);
            chk("vec_out_valid", out_valid, 1);
            chk("vec_out_data", out_data, vecs[i].exp_data);
            chk("vec_out_neg", out_neg, vecs[i].exp_neg);
            chk("vec_out_tag", out_tag, vecs[i].tag);
            @(posedge clk);
            #1;
        end

        // Stall: tags 1,2,3 back-to-back, out_ready low 4 cycles then high
        outq.delete();
        hold_chk  = 1'b0;
        out_ready = 1'b0;
        n = 1;
        stall_acc = 0;
        in_valid = 1'b1;
        in_fmt   = 2'b00;
        in_field = 22'h000100;
        in_tag   = 5'd1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (accepted) begin
                stall_acc++;
                n++;
                if (n > 3) in_valid = 1'b0;
                in_field = 22'h000100 * n;
                in_tag   = TAG_W'(n);
            end
        end
        chk("stall_accepts", stall_acc, CAP);
        out_ready = 1'b1;
        guard = 0;
        while ((n <= 3 || sb.size() > 0) && guard < 50) begin
            step();
            if (accepted) begin
                n++;
                if (n > 3) in_valid = 1'b0;
                in_field = 22'h000100 * n;
                in_tag   = TAG_W'(n);
            end
            guard++;
        end
        chk("stall_drain_count", outq.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < outq.size()) chk("stall_order", outq[k], k + 1);
        end
        $display("stall sequence accepts_during_stall=%0d outputs=%0d", stall_acc, outq.size());

        // Random valid/ready traffic
        nout = 0;
        in_valid = 1'b0;
        accepted = 1'b0;
        guard = 0;
        while (nout < 1000 && guard < 20000) begin
            if (!in_valid || accepted) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_field = IN_W'($urandom);
                in_fmt   = 2'($urandom_range(0, 3));
                in_tag   = TAG_W'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            guard++;
        end
        chk("random_transfers", nout, 1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            step();
            guard++;
        end
        chk("random_drained", sb.size(), 0);
        $display("random traffic outputs=%0d cycles=%0d", nout, guard);

        // Reset mid-stall with the stage full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = 2'b10;
        n = 10;
        in_field  = 22'h00000A;
        in_tag    = 5'd10;
        guard = 0;
        while (sb.size() < CAP && guard < 10) begin
            step();
            if (accepted) begin
                n++;
                in_field = IN_W'(n);
                in_tag   = TAG_W'(n);
            end
            guard++;
        end
        chk("fill_before_reset", sb.size(), CAP);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        sb.delete();
        outq.delete();
        hold_chk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_fmt    = 2'b01;
        in_field  = 22'h3ABCDE;
        in_tag    = 5'd20;
        step();
        in_valid = 1'b0;
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            step();
            guard++;
        end
        chk("post_reset_outputs", outq.size(), 1);
        if (outq.size() > 0) chk("post_reset_first_tag", outq[0], 20);
        $display("reset mid-stall first_tag_after=%0d", (outq.size() > 0) ? outq[0] : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered, flow-controlled immediate extension stage for the PikaRISC decode path. It takes a raw instruction immediate field plus a format select and produces a DATA_W-bit operand. Supported formats are sign-extended short immediate, sign-extended memory displacement, zero-extended immediate, and upper-immediate. It sits between decode and the operand mux, and replaces the purely combinational extenders with a valid/ready pipeline stage that carries a tag alongside the data.

## Interface
- DATA_W, 32: output operand width.
- IMM_W, 18: short immediate field width; 2 ≤ IMM_W < DATA_W.
- MD_W, 22: memory displacement field width; 2 ≤ MD_W < DATA_W.
- UP_W, 14: upper-immediate field width; 1 ≤ UP_W ≤ DATA_W.
- TAG_W, 5: sideband tag width (destination register index); passed through unmodified.
- IN_W, derived as max(IMM_W, MD_W, UP_W): width of the raw field input.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream holds a field.
- in_ready  out  1  stage accepts this cycle.
- in_field  in  IN_W  raw immediate, LSB-aligned; bits above the selected format width are ignored.
- in_fmt  in  2  format: 00 SEXT_IMM, 01 SEXT_MD, 10 ZEXT_IMM, 11 UPPER.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  extended operand.
- out_tag  out  TAG_W  tag accepted with the field.
- out_neg  out  1  out_data[DATA_W-1].

## Operation
- Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
- SEXT_IMM: out_data = field[IMM_W-1:0] with bit IMM_W-1 replicated into the upper DATA_W-IMM_W bits.
- SEXT_MD: same rule using MD_W.
- ZEXT_IMM: out_data = field[IMM_W-1:0], upper bits 0.
- UPPER: out_data = field[UP_W-1:0] << (DATA_W-UP_W), lower bits 0. When UP_W = DATA_W there is no shift.
- Extension is computed at input acceptance. Stored entries hold the extended value, not the raw field.
- Output register state: EMPTY (out_valid=0) or FULL (out_valid=1).
  - EMPTY + transfer in → FULL.
  - FULL + transfer out with no transfer in → EMPTY.
  - FULL + transfer out + transfer in → FULL, loaded with the new value.
  - FULL with no transfer out holds out_data and out_tag stable.
- out_data and out_tag never change while out_valid=1 and out_ready=0.
- Order is strictly preserved. No entry is dropped or duplicated.

## Timing
- Latency: 1 cycle from transfer in to out_valid, given an empty stage.
- Throughput: 1 per cycle when out_ready is held high.
- Reset values: out_valid=0, out_data=0, out_tag=0, out_neg=0. in_ready is 1 in the first cycle after deassertion.
- Reset asserted mid-operation discards all held entries asynchronously; no output transfer completes in that cycle.
- in_valid may rise while in_ready=0. Upstream holds its data until a transfer in occurs.

## Configuration
- IMMEXT_SKID_EN defined:
  - Adds a one-entry skid register behind the output register.
  - in_ready is a flop output equal to "skid empty", with no combinational path from out_ready.
  - A transfer in while the output is FULL and stalled fills the skid; in_ready falls on the next cycle.
  - When the output drains, the skid moves to the output in the same edge and in_ready rises the next cycle.
  - Maximum of 2 entries in flight.
- IMMEXT_SKID_EN undefined:
  - Single output register only.
  - in_ready = !out_valid | out_ready (combinational).
  - Maximum of 1 entry in flight.

## Structure
- Shared package `pika_pkg`: the 2-bit format typedef with enum constants FMT_SEXT_IMM/FMT_SEXT_MD/FMT_ZEXT_IMM/FMT_UPPER, plus the default widths DATA_W/IMM_W/MD_W.
- Sub-module `imm_extend_core`: purely combinational format → operand function. It is instantiated once at the input, so skid and output hold post-extension values.

## Test plan
- Reset checks: with rst_n=0, out_valid=0 and out_data=0; after release, in_ready=1.
- Sign extension, out_ready=1:
  - SEXT_IMM field 0x20000 → 0xFFFE0000, out_neg=1, one cycle later.
  - SEXT_IMM field 0x1FFFF → 0x0001FFFF.
  - SEXT_MD field 0x200001 → 0xFFE00001.
- Zero extension and upper immediate:
  - ZEXT_IMM field 0x3FFFF with junk in upper IN_W bits → 0x0003FFFF.
  - UPPER field 0x2ABC → 0xAAF00000.
- Stall: send tags 1, 2, 3 back-to-back with out_ready=0 for 4 cycles, then 1.
  - With SKID_EN, in_ready falls after 2 accepts.
  - Without SKID_EN, in_ready falls after 1 accept.
  - Outputs appear in order 1, 2, 3 with data stable throughout the stall.
- Random valid/ready: 1000 random transfers against a scoreboard show no loss, no duplication, and full-throughput cycles whenever both sides are high.
- Reset mid-stall: with 2 entries held, pulse rst_n low. out_valid=0 immediately; after release, the next accepted value is the first output.
